// File: rtl/fifo_port_scheduler.sv
// Round-robin writer arbiter and single-reader scheduler driving the strobes of a small sync FIFO.
// Latency: decision in cycle N, registered strobes/gnt in N+1, rd_valid with data in N+2.
// Backpressure: writers hold req until gnt and the reader holds rd_req until rd_valid; stalls on local credit count.
module fifo_port_scheduler #(
    parameter int DATA_WIDTH = 6,
    parameter int DEPTH      = 3,
    parameter int NREQ       = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NREQ-1:0]              req,
    input  logic [NREQ*DATA_WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]              gnt,
    input  logic                         rd_req,
    output logic                         rd_valid,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic                         fifo_wr_en,
    output logic [DATA_WIDTH-1:0]        fifo_dat_in,
    output logic                         fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]        fifo_dat_out,
    input  logic                         fifo_full,
    input  logic                         fifo_empty,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic                         err
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = $clog2(NREQ);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic {
        OP_WRITE = 1'b0,
        OP_READ  = 1'b1
    } op_t;

    logic [CW-1:0]         count;
    logic [CW-1:0]         count_d;
    logic [PW-1:0]         rr_ptr;
    op_t                   last_op;
    logic                  rd_pending;
    logic                  chk_en;

    logic [NREQ-1:0]       wr_cand;
    logic                  wr_found;
    logic [PW-1:0]         wr_idx;
    logic [PW-1:0]         probe;
    logic [DATA_WIDTH-1:0] wr_dat_sel;
    logic                  wr_elig;
    logic                  rd_elig;
    logic                  do_wr;
    logic                  do_rd;
    logic                  flag_mismatch;

    assign rd_data   = fifo_dat_out;
    assign occupancy = count;

    // Round-robin search starting just after the last granted writer; a writer
    // whose gnt is showing this cycle has not yet dropped req, so it is masked.
    always_comb begin
        wr_cand  = req & ~gnt;
        wr_found = 1'b0;
        wr_idx   = '0;
        probe    = '0;
        for (int k = 0; k < NREQ; k++) begin
            probe = PW'((int'(rr_ptr) + k + 1) % NREQ);
            if (!wr_found && wr_cand[probe]) begin
                wr_found = 1'b1;
                wr_idx   = probe;
            end
        end
    end

    // Select the winning writer's data slice.
    always_comb begin
        wr_dat_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (wr_idx == PW'(i)) begin
                wr_dat_sel = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Read/write choice from the local credit count; contested cycles alternate
    // against the last issued operation. Flag check uses the count delayed to
    // line up with the FIFO's registered flags.
    always_comb begin
        wr_elig       = wr_found && (count < FULL_CNT);
        rd_elig       = rd_req && !rd_pending && (count != '0);
        do_rd         = rd_elig && (!wr_elig || (last_op == OP_WRITE));
        do_wr         = wr_elig && !do_rd;
        flag_mismatch = (fifo_full  != (count_d == FULL_CNT)) ||
                        (fifo_empty != (count_d == '0));
    end

    // Registered strobes, credit count, arbitration state and sticky error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt         <= '0;
            fifo_wr_en  <= 1'b0;
            fifo_rd_en  <= 1'b0;
            fifo_dat_in <= '0;
            rd_valid    <= 1'b0;
            count       <= '0;
            count_d     <= '0;
            rr_ptr      <= '0;
            last_op     <= OP_WRITE;
            rd_pending  <= 1'b0;
            chk_en      <= 1'b0;
            err         <= 1'b0;
        end else begin
            fifo_wr_en <= do_wr;
            fifo_rd_en <= do_rd;
            rd_valid   <= fifo_rd_en;
            gnt        <= do_wr ? (NREQ'(1) << wr_idx) : '0;
            count_d    <= count;
            chk_en     <= 1'b1;
            if (do_wr) begin
                fifo_dat_in <= wr_dat_sel;
                rr_ptr      <= wr_idx;
                last_op     <= OP_WRITE;
                count       <= count + 1'b1;
            end else if (do_rd) begin
                last_op     <= OP_READ;
                count       <= count - 1'b1;
            end
            // Pending covers the strobe cycle and the rd_valid cycle.
            if (do_rd) begin
                rd_pending <= 1'b1;
            end else if (rd_valid) begin
                rd_pending <= 1'b0;
            end
            if (chk_en && flag_mismatch) begin
                err <= 1'b1;
            end
        end
    end

endmodule
